dma_axi_wr_arbiter: RTL and testbench
=====================================

Name: dma_axi_wr_arbiter

Overview:
Shares the DMA controller's single AXI write master port (AW/W/B, port suffix 0) among NUM_CH DMA channel write engines. Round-robin arbitration grants one channel a full burst: address, then all data beats, then the write response. The response is routed back to the owning channel. Exactly one burst is outstanding at a time. The block sits between the per-channel write engines and the AXI write channels of the bus interface.

Parameters:
NUM_CH, 4, number of requesting channels (2..16); AWID0/WID0 carry the channel index
ID_BITS, 4, AXI ID width; must satisfy 2**ID_BITS >= NUM_CH
LEN_BITS, 4, AXI burst length field width (beats = len+1)
SIZE_BITS, 2, AXI burst size field width
ADDR_W, 32, address width
DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
req_valid  in  NUM_CH  channel c requests a burst
req_ready  out  NUM_CH  one-hot; request of channel c accepted this cycle
req_addr  in  NUM_CH*ADDR_W  per-channel burst start address, channel c at slice c
req_len  in  NUM_CH*LEN_BITS  per-channel burst length
req_size  in  NUM_CH*SIZE_BITS  per-channel burst size
ch_wdata  in  NUM_CH*DATA_W  per-channel write data
ch_wstrb  in  NUM_CH*DATA_W/8  per-channel write strobes
ch_wvalid  in  NUM_CH  per-channel data valid
ch_wready  out  NUM_CH  per-channel data ready; only the granted bit can be 1
ch_done  out  NUM_CH  one-cycle pulse when the owning burst's B response is received
ch_bresp  out  2  BRESP0 captured with ch_done
id_err  out  1  sticky; BID0 did not match the granted channel
AWID0/AWADDR0/AWLEN0/AWSIZE0/AWVALID0  out  ID_BITS/ADDR_W/LEN_BITS/SIZE_BITS/1  AXI write address
AWREADY0  in  1
WID0/WDATA0/WSTRB0/WLAST0/WVALID0  out  ID_BITS/DATA_W/DATA_W/8/1/1  AXI write data
WREADY0  in  1
BID0/BRESP0/BVALID0  in  ID_BITS/2/1  AXI write response
BREADY0  out  1

Behaviour:
- Reset behaviour:
  - Every registered output is 0, including AWVALID0, WVALID0, BREADY0, ch_done, id_err and all AW fields.
  - FSM = IDLE, rr pointer = 0, beat counter = 0.
  - Reset mid-burst abandons the burst; the master port is quiet on the next cycle. No ch_done is produced for the aborted burst.
- FSM states: IDLE -> AW -> W -> B -> IDLE.
- IDLE:
  - If any req_valid is set, grant g = the first set bit scanning from rr_ptr upward, mod NUM_CH.
  - req_ready[g] = 1 combinationally in that same cycle.
  - Latch addr/len/size of channel g and g itself; go to AW.
  - No request: stay in IDLE; req_ready = 0.
- AW:
  - AWVALID0 = 1 from the first AW cycle, i.e. 1 cycle after grant.
  - AWID0 = WID0 = g zero-extended; AW fields are stable while AWVALID0 && !AWREADY0.
  - On AWVALID0 && AWREADY0: drop AWVALID0 next cycle, clear beat counter, go to W.
- W:
  - Combinational pass-through: WVALID0 = ch_wvalid[g], ch_wready[g] = WREADY0, WDATA0/WSTRB0 = slice g.
  - Other channels see ch_wready = 0.
  - WLAST0 = (beat == latched len).
  - Each WVALID0 && WREADY0 increments beat.
  - The handshake with WLAST0 = 1 moves to B. A len=0 burst has a single beat with WLAST0 = 1.
  - Data is never issued before the AW handshake.
- B:
  - BREADY0 = 1 (registered, set on entry).
  - On BVALID0: ch_done[g] pulses 1 cycle (registered) with ch_bresp = BRESP0.
  - If BID0 != g, set id_err; the done is still delivered to g.
  - rr_ptr = (g+1) mod NUM_CH; BREADY0 drops; go to IDLE.
- Throughput: minimum burst cost is 1 (grant) + 1 (AW) + len+1 (W) + 1 (B) cycles; IDLE can re-grant in the cycle after B completes.
- Simultaneous requests: only one grant per arbitration; the others wait. Round robin guarantees each requester a grant within NUM_CH bursts.
- A requester must hold req_valid and its request fields until req_ready. Deasserting earlier is legal; it is then simply not granted.
- req_valid from the owning channel during AW/W/B is ignored until IDLE.
- BVALID0 outside state B is ignored; BREADY0 = 0 there.

Test Plan:
- Single channel: reset, then ch1 req addr=0x1000 len=3 size=3, slave always ready → req_ready[1] in the grant cycle; AWVALID0 the next cycle with AWID0=1, AWADDR0=0x1000, AWLEN0=3; 4 W beats with WLAST0 on beat 4; BRESP0=0 → ch_done[1] pulse, ch_bresp=0.
- All 4 channels request continuously with len=0 → grants in order 0,1,2,3,0; each ch_done exactly once per burst; no gaps beyond the stated minimum cycle count.
- Backpressure: AWREADY0 held low 5 cycles, then WREADY0 toggling → AW fields stable throughout; each beat's data matches ch_wdata; beat count is exactly len+1.
- Error response: BRESP0=2 and BID0=3 while ch2 is granted → ch_bresp=2, ch_done[2] pulses, id_err=1 and stays 1 until reset.
- Reset asserted during beat 2 of an 8-beat burst → the next cycle shows AWVALID0=WVALID0=BREADY0=0 with the FSM in IDLE; the following request is granted normally from rr_ptr=0.
- len=0 with ch_wvalid delayed 3 cycles → WVALID0 stays low until then; the single beat carries WLAST0=1; no req_ready is issued to other channels until B completes.

Source files
------------

// File: rtl/dma_axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master (AW/W/B) among NUM_CH DMA write engines.
// One burst is outstanding at a time: grant, address, all data beats, then the response.
module dma_axi_wr_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               req_valid,
  output logic [NUM_CH-1:0]               req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]        req_addr,
  input  logic [NUM_CH*LEN_BITS-1:0]      req_len,
  input  logic [NUM_CH*SIZE_BITS-1:0]     req_size,
  input  logic [NUM_CH*DATA_W-1:0]        ch_wdata,
  input  logic [(NUM_CH*DATA_W/8)-1:0]    ch_wstrb,
  input  logic [NUM_CH-1:0]               ch_wvalid,
  output logic [NUM_CH-1:0]               ch_wready,
  output logic [NUM_CH-1:0]               ch_done,
  output logic [1:0]                      ch_bresp,
  output logic                            id_err,
  output logic [ID_BITS-1:0]              AWID0,
  output logic [ADDR_W-1:0]               AWADDR0,
  output logic [LEN_BITS-1:0]             AWLEN0,
  output logic [SIZE_BITS-1:0]            AWSIZE0,
  output logic                            AWVALID0,
  input  logic                            AWREADY0,
  output logic [ID_BITS-1:0]              WID0,
  output logic [DATA_W-1:0]               WDATA0,
  output logic [(DATA_W/8)-1:0]           WSTRB0,
  output logic                            WLAST0,
  output logic                            WVALID0,
  input  logic                            WREADY0,
  input  logic [ID_BITS-1:0]              BID0,
  input  logic [1:0]                      BRESP0,
  input  logic                            BVALID0,
  output logic                            BREADY0
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       gnt;
  logic [GW-1:0]       gnt_nxt;
  logic [GW-1:0]       idx;
  logic                gnt_any;
  logic [LEN_BITS-1:0] beat;
  logic                last_beat;

  // First requester at or above rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_nxt = rr_ptr;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = GW'((32'(rr_ptr) + i) % NUM_CH);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_nxt = idx;
      end
    end
  end

  assign last_beat = (beat == AWLEN0);
  assign AWID0     = ID_BITS'(gnt);
  assign WID0      = ID_BITS'(gnt);
  assign WDATA0    = ch_wdata[gnt*DATA_W +: DATA_W];
  assign WSTRB0    = ch_wstrb[gnt*SW +: SW];
  assign WLAST0    = (state == S_W) && last_beat;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    ch_wready = '0;
    WVALID0   = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          req_ready[gnt_nxt] = 1'b1;
          state_nxt          = S_AW;
        end
      end
      S_AW: begin
        if (AWVALID0 && AWREADY0) state_nxt = S_W;
      end
      S_W: begin
        WVALID0        = ch_wvalid[gnt];
        ch_wready[gnt] = WREADY0;
        if (ch_wvalid[gnt] && WREADY0 && last_beat) state_nxt = S_B;
      end
      S_B: begin
        if (BVALID0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      beat     <= '0;
      AWADDR0  <= '0;
      AWLEN0   <= '0;
      AWSIZE0  <= '0;
      AWVALID0 <= 1'b0;
      BREADY0  <= 1'b0;
      ch_done  <= '0;
      ch_bresp <= '0;
      id_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch_done <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            gnt      <= gnt_nxt;
            AWADDR0  <= req_addr[gnt_nxt*ADDR_W +: ADDR_W];
            AWLEN0   <= req_len[gnt_nxt*LEN_BITS +: LEN_BITS];
            AWSIZE0  <= req_size[gnt_nxt*SIZE_BITS +: SIZE_BITS];
            AWVALID0 <= 1'b1;
          end
        end
        S_AW: begin
          if (AWREADY0) begin
            AWVALID0 <= 1'b0;
            beat     <= '0;
          end
        end
        S_W: begin
          if (ch_wvalid[gnt] && WREADY0) begin
            beat <= beat + 1'b1;
            if (last_beat) BREADY0 <= 1'b1;
          end
        end
        S_B: begin
          if (BVALID0) begin
            ch_done[gnt] <= 1'b1;
            ch_bresp     <= BRESP0;
            BREADY0      <= 1'b0;
            if (BID0 != ID_BITS'(gnt)) id_err <= 1'b1;
            rr_ptr <= (gnt == GW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_axi_wr_arbiter.sv
// Scoreboard bench for dma_axi_wr_arbiter: random channel engines and AXI slave,
// expected grants/AW/W/B derived from a round-robin request model.
module tb_dma_axi_wr_arbiter;
  localparam int NC  = 4;
  localparam int IB  = 4;
  localparam int LB  = 4;
  localparam int SB  = 2;
  localparam int AWD = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NC-1:0]        req_valid, req_ready;
  logic [NC*AWD-1:0]    req_addr;
  logic [NC*LB-1:0]     req_len;
  logic [NC*SB-1:0]     req_size;
  logic [NC*DW-1:0]     ch_wdata;
  logic [NC*SW-1:0]     ch_wstrb;
  logic [NC-1:0]        ch_wvalid, ch_wready, ch_done;
  logic [1:0]           ch_bresp;
  logic                 id_err;
  logic [IB-1:0]        AWID0, WID0, BID0;
  logic [AWD-1:0]       AWADDR0;
  logic [LB-1:0]        AWLEN0;
  logic [SB-1:0]        AWSIZE0;
  logic                 AWVALID0, AWREADY0, WLAST0, WVALID0, WREADY0, BVALID0, BREADY0;
  logic [DW-1:0]        WDATA0;
  logic [SW-1:0]        WSTRB0;
  logic [1:0]           BRESP0;

  dma_axi_wr_arbiter #(.NUM_CH(NC), .ID_BITS(IB), .LEN_BITS(LB), .SIZE_BITS(SB),
                       .ADDR_W(AWD), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
    .ch_done(ch_done), .ch_bresp(ch_bresp), .id_err(id_err),
    .AWID0(AWID0), .AWADDR0(AWADDR0), .AWLEN0(AWLEN0), .AWSIZE0(AWSIZE0),
    .AWVALID0(AWVALID0), .AWREADY0(AWREADY0),
    .WID0(WID0), .WDATA0(WDATA0), .WSTRB0(WSTRB0), .WLAST0(WLAST0),
    .WVALID0(WVALID0), .WREADY0(WREADY0),
    .BID0(BID0), .BRESP0(BRESP0), .BVALID0(BVALID0), .BREADY0(BREADY0)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [AWD-1:0] addr; int len; int size; } aw_t;
  typedef struct { int ch; logic [DW-1:0] data; logic [SW-1:0] strb; bit last; } w_t;
  typedef struct { int ch; int resp; int cyc; } d_t;
  aw_t aw_q[$];
  w_t  w_q[$];
  d_t  d_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic bit rnd(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  function automatic logic [DW-1:0] beat_data(input int c, input int n, input int k);
    return {8'(c), 16'(n), 8'(k), 32'(c * 32'h9E3779B1 ^ n * 32'h85EBCA6B ^ k * 32'hC2B2AE35)};
  endfunction

  function automatic logic [SW-1:0] beat_strb(input int c, input int n, input int k);
    return SW'(c * 37 + n * 11 + k * 5 + 1);
  endfunction

  // Reference model and stimulus state
  int owner = -1;
  int m_rr = 0;
  int burst_n[NC];
  int beat_k[NC];
  int len_c[NC];
  int size_c[NC];
  int since_gnt = 0;
  bit aw_chk = 0;
  bit exp_id_err = 0;
  bit b_armed = 0;
  int b_cnt = 0;
  int b_id_v = 0;
  int b_resp_v = 0;
  int p_awr = 100, p_wr = 100, p_wv = 100, p_noise = 0, p_req = 0, p_bad = 0;
  int force_resp = -1, force_bid = -1, wv_delay = 0, bdly_max = 0, aw_hold = 0, len_max = 0;

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; req_size = '0;
    ch_wdata = '0; ch_wstrb = '0; ch_wvalid = '0;
    AWREADY0 = 1'b0; WREADY0 = 1'b0; BVALID0 = 1'b0; BID0 = '0; BRESP0 = '0;
  endtask

  task automatic new_req(input int c, input logic [AWD-1:0] addr, input int len, input int size);
    req_valid[c] = 1'b1;
    req_addr[c*AWD +: AWD] = addr;
    req_len[c*LB +: LB] = LB'(len);
    req_size[c*SB +: SB] = SB'(size);
    len_c[c] = len;
    size_c[c] = size;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    aw_q.delete(); w_q.delete(); d_q.delete();
    owner = -1; m_rr = 0; exp_id_err = 0; b_armed = 0; aw_chk = 0;
    for (int c = 0; c < NC; c++) burst_n[c]++;
    @(posedge clk);
    @(negedge clk);
    chk("reset_quiet", 128'({AWVALID0, WVALID0, BREADY0, ch_done, id_err, req_ready, AWADDR0, AWLEN0, AWID0}), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: model checks at negedge, then stimulus/model update just after posedge.
  task automatic step();
    int exp_g;
    int idx;
    int g;
    logic [NC-1:0] exp_rdy;
    bit s_gnt, s_wfire, s_wlast, s_bfire;
    @(negedge clk);
    if (aw_chk) begin
      chk("aw_after_grant", 128'(AWVALID0), 128'(1));
      aw_chk = 0;
    end
    exp_g = -1;
    if (owner == -1)
      for (int i = 0; i < NC; i++) begin
        idx = (m_rr + i) % NC;
        if (exp_g < 0 && req_valid[idx]) exp_g = idx;
      end
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    s_gnt = (exp_g >= 0);
    s_wfire = 0;
    if (owner >= 0) s_wfire = ch_wvalid[owner] && ch_wready[owner];
    s_wlast = WVALID0 && WREADY0 && WLAST0;
    s_bfire = BVALID0 && BREADY0;
    @(posedge clk);
    #1;
    if (s_wfire) beat_k[owner]++;
    if (s_bfire && owner >= 0) begin
      d_q.push_back('{owner, b_resp_v, cyc});
      if (b_id_v != owner) exp_id_err = 1;
      burst_n[owner]++;
      owner = -1;
      BVALID0 = 1'b0;
      b_armed = 0;
    end
    if (s_wlast) begin
      b_armed = 1;
      b_cnt = $urandom_range(bdly_max, 0);
    end
    if (s_gnt) begin
      g = exp_g;
      owner = g; m_rr = (g + 1) % NC;
      req_valid[g] = 1'b0;
      beat_k[g] = 0; since_gnt = 0; aw_chk = 1;
      aw_q.push_back('{g, req_addr[g*AWD +: AWD], len_c[g], size_c[g]});
      for (int k = 0; k <= len_c[g]; k++)
        w_q.push_back('{g, beat_data(g, burst_n[g], k), beat_strb(g, burst_n[g], k), k == len_c[g]});
    end
    if (b_armed && !BVALID0 && owner >= 0) begin
      if (b_cnt == 0) begin
        b_id_v = (force_bid >= 0) ? force_bid
               : rnd(p_bad) ? (owner + 1 + $urandom_range(14, 0)) % 16 : owner;
        b_resp_v = (force_resp >= 0) ? force_resp : $urandom_range(3, 0);
        BVALID0 = 1'b1; BID0 = IB'(b_id_v); BRESP0 = 2'(b_resp_v);
      end else b_cnt--;
    end
    since_gnt++;
    AWREADY0 = (since_gnt > aw_hold) && rnd(p_awr);
    WREADY0 = rnd(p_wr);
    for (int c = 0; c < NC; c++) begin
      if (c == owner && beat_k[c] <= len_c[c] && since_gnt > wv_delay) begin
        ch_wvalid[c] = rnd(p_wv);
        ch_wdata[c*DW +: DW] = beat_data(c, burst_n[c], beat_k[c]);
        ch_wstrb[c*SW +: SW] = beat_strb(c, burst_n[c], beat_k[c]);
      end else if (c != owner) begin
        ch_wvalid[c] = rnd(p_noise);
        ch_wdata[c*DW +: DW] = {$urandom, $urandom};
        ch_wstrb[c*SW +: SW] = SW'($urandom);
      end else ch_wvalid[c] = 1'b0;
      if (!req_valid[c] && c != owner && rnd(p_req))
        new_req(c, $urandom, $urandom_range(len_max, 0), $urandom_range(3, 0));
    end
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    i = 0;
    while ((owner != -1 || req_valid != '0 || d_q.size() != 0) && i < maxc) begin
      step();
      i++;
    end
    if (owner != -1 || req_valid != '0 || d_q.size() != 0) begin
      fail("timeout_waiting_idle");
      do_reset();
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer.
  always @(negedge clk) begin
    if (!reset) begin
      logic [NC-1:0] own_mask;
      logic [NC-1:0] oh;
      own_mask = '0;
      if (w_q.size() > 0) own_mask[w_q[0].ch] = 1'b1;
      chk("ch_wready_iso", 128'(ch_wready & ~own_mask), '0);
      if (WVALID0) begin
        if (aw_q.size() != 0 || w_q.size() == 0) fail("w_unexpected");
        else if (WREADY0) begin
          w_t e;
          e = w_q.pop_front();
          chk("w_beat", 128'({WID0, WDATA0, WSTRB0, WLAST0}),
              128'({IB'(e.ch), e.data, e.strb, e.last}));
        end
      end
      if (AWVALID0) begin
        if (aw_q.size() == 0) fail("aw_unexpected");
        else begin
          chk("aw_fields", 128'({AWID0, AWADDR0, AWLEN0, AWSIZE0}),
              128'({IB'(aw_q[0].id), aw_q[0].addr, LB'(aw_q[0].len), SB'(aw_q[0].size)}));
          if (AWREADY0) void'(aw_q.pop_front());
        end
      end
      if (ch_done != '0) begin
        if (d_q.size() == 0) fail("done_unexpected");
        else begin
          d_t e;
          e = d_q.pop_front();
          oh = '0;
          oh[e.ch] = 1'b1;
          chk("done", 128'({ch_done, ch_bresp}), 128'({oh, 2'(e.resp)}));
        end
      end else if (d_q.size() > 0 && d_q[0].cyc < cyc) begin
        fail("done_missing");
        void'(d_q.pop_front());
      end
      chk("id_err", 128'(id_err), 128'(exp_id_err));
    end
  end

  initial begin
    clear_inputs();
    for (int c = 0; c < NC; c++) begin burst_n[c] = 0; beat_k[c] = 0; len_c[c] = 0; size_c[c] = 0; end
    do_reset();

    // single channel, always-ready slave
    new_req(1, 32'h1000, 3, 3);
    wait_idle(50);

    // all channels continuously, len 0, minimum spacing
    do_reset();
    p_req = 100; len_max = 0;
    repeat (40) step();
    p_req = 0;
    wait_idle(50);

    // AW held off 5 cycles, W ready toggling
    aw_hold = 5; p_wr = 50;
    new_req(0, 32'hABCD_0040, 5, 2);
    wait_idle(100);
    aw_hold = 0; p_wr = 100;

    // error response with wrong BID on channel 2, then a clean burst
    force_resp = 2; force_bid = 3;
    new_req(2, 32'h2000, 1, 3);
    wait_idle(50);
    force_resp = -1; force_bid = -1;
    new_req(0, 32'h3000, 0, 1);
    wait_idle(50);

    // reset during an 8-beat burst, then re-arbitration from pointer 0
    new_req(3, 32'h4000, 7, 3);
    p_wv = 100; p_wr = 100;
    for (int i = 0; i < 60 && beat_k[3] < 2; i++) step();
    if (beat_k[3] < 2) fail("reset_burst_not_started");
    do_reset();
    new_req(1, 32'h5000, 1, 0);
    new_req(3, 32'h6000, 1, 0);
    wait_idle(80);

    // len 0 with data delayed, other channels waiting
    wv_delay = 3; p_noise = 50;
    new_req(0, 32'h7000, 0, 3);
    new_req(1, 32'h7100, 2, 3);
    new_req(2, 32'h7200, 0, 3);
    wait_idle(80);
    wv_delay = 0;

    // randomized traffic
    p_awr = 60; p_wr = 60; p_wv = 70; p_noise = 30; p_req = 30; p_bad = 10;
    bdly_max = 3; len_max = 7;
    repeat (1500) step();
    p_req = 0;
    wait_idle(600);
    repeat (3) step();
    if (aw_q.size() != 0 || w_q.size() != 0) fail("queues_not_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    fail("global_time_limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
